// File: rtl/gray_ticket_pkg.sv
// Shared types and helpers for the Gray-coded ticket arbiter.
package gray_ticket_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    // Widest counter the helper handles; callers zero-extend and truncate.
    localparam int GRAY_MAXW = 32;

    function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, modulo NREQ.
module gray_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   idx
);

    localparam logic [PW:0] NREQ_W = (PW+1)'(NREQ);

    logic [NREQ-1:0] rot;
    logic [PW-1:0]   off;
    logic [PW:0]     sum;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        any = |req;
        // Doubling req lets a plain shift act as a rotate by ptr.
        rot = NREQ'({req, req} >> ptr);
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = PW'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NREQ_W) sum = sum - NREQ_W;
        idx = sum[PW-1:0];
    end

endmodule

// File: rtl/gray_ticket_arb.sv
// Round-robin sequencer handing out Gray-coded tickets from one shared counter.
module gray_ticket_arb
    import gray_ticket_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int CBITS = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             hold,
    input  logic             clr,
    output logic [NREQ-1:0]  gnt,
    output logic [CBITS-1:0] ticket,
    output logic             wrap,
    output logic             zero,
    output logic             busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    win_q, win_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [CBITS-1:0] ticket_q, ticket_d;
    logic             wrap_q, wrap_d;

    logic             pick_any;
    logic [PW-1:0]    pick_idx;

    gray_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        ticket_d = ticket_q;
        gnt_d    = '0;
        wrap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (!hold && pick_any) begin
                    gnt_d    = NREQ'(1) << pick_idx;
                    ticket_d = CBITS'(bin2gray(GRAY_MAXW'(cnt_q)));
                    wrap_d   = &cnt_q;
                    win_d    = pick_idx;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                // Inputs are ignored here; the grant already issued always completes.
                cnt_d   = cnt_q + CBITS'(1);
                ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            win_q    <= '0;
            gnt_q    <= '0;
            ticket_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            gnt_q    <= gnt_d;
            ticket_q <= ticket_d;
            wrap_q   <= wrap_d;
        end
    end

    assign gnt    = gnt_q;
    assign ticket = ticket_q;
    assign wrap   = wrap_q;
    assign zero   = (cnt_q == '0) & ~rst;
    assign busy   = (state_q == GRANT);

endmodule
